// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg
//   Shared constants and types for the fractal sync node register files.
//   - MIN_N_PORTS  : smallest port count a barrier register file supports.
//   - DEF_N_PORTS  : port count of the default node configuration.
//   - port_mask_t  : per-entry arrival mask for the default configuration.
//     Modules with a different port count declare the same shape locally
//     from their own N_PORTS parameter.
package fractal_sync_pkg;

  localparam int unsigned MIN_N_PORTS = 2;
  localparam int unsigned DEF_N_PORTS = 4;

  typedef logic [DEF_N_PORTS-1:0] port_mask_t;

endpackage

// File: rtl/fractal_sync_mask_rf.sv
// fractal_sync_mask_rf
//   Storage for the barrier arrival masks: N_REGS entries of N_PORTS bits.
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset, clears every entry
//     i_clear  synchronous flush of every entry (wins over writes)
//     i_we     per-entry write enable
//     i_wdata  per-entry next value, entry r at [r*N_PORTS +: N_PORTS]
//     o_mask   current entries, same packing as i_wdata
module fractal_sync_mask_rf #(
  parameter int unsigned N_REGS  = 4,
  parameter int unsigned N_PORTS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  input  logic [N_REGS-1:0]           i_we,
  input  logic [N_REGS*N_PORTS-1:0]   i_wdata,
  output logic [N_REGS*N_PORTS-1:0]   o_mask
);

  logic [N_REGS*N_PORTS-1:0] r_mask;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= '0;
    end else if (i_clear) begin
      r_mask <= '0;
    end else begin
      for (int r = 0; r < int'(N_REGS); r++) begin
        if (i_we[r]) begin
          r_mask[r*N_PORTS +: N_PORTS] <= i_wdata[r*N_PORTS +: N_PORTS];
        end
      end
    end
  end

  assign o_mask = r_mask;

endmodule

// File: rtl/fractal_sync_np_local_rf.sv
// fractal_sync_np_local_rf
//   N-port local barrier register file. Each entry records which ports have
//   checked in on that barrier ID; the entry completes (and is freed) in the
//   cycle the last participating port arrives. All responses are
//   combinational in the cycle of the check.
//   Ports:
//     clk_i        clock
//     rst_ni       asynchronous active-low reset
//     id_i         barrier ID per port, port i at [i*ID_WIDTH +: ID_WIDTH]
//     check_i      arrival strobe per port
//     part_mask_i  participating ports (change only while pending_o == 0)
//     clear_i      synchronous flush of all entries
//     present_o    entry for id_i[i] already held arrivals before this cycle
//     done_o       this arrival completes the barrier
//     id_err_o     ID out of range, or port not participating
//     dup_err_o    port already checked in on this entry
//     bypass_o     a barrier completed entirely within this cycle
//     pending_o    per-entry "mask is nonzero"
module fractal_sync_np_local_rf
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_REGS   = 4,
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned N_PORTS  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_PORTS*ID_WIDTH-1:0]  id_i,
  input  logic [N_PORTS-1:0]           check_i,
  input  logic [N_PORTS-1:0]           part_mask_i,
  input  logic                         clear_i,
  output logic [N_PORTS-1:0]           present_o,
  output logic [N_PORTS-1:0]           done_o,
  output logic [N_PORTS-1:0]           id_err_o,
  output logic [N_PORTS-1:0]           dup_err_o,
  output logic                         bypass_o,
  output logic [N_REGS-1:0]            pending_o
);

  if (N_PORTS < MIN_N_PORTS) begin : g_bad_n_ports
    $error("fractal_sync_np_local_rf: N_PORTS must be at least 2");
  end
  if ((2 ** ID_WIDTH) < N_REGS) begin : g_bad_id_width
    $error("fractal_sync_np_local_rf: ID_WIDTH too narrow for N_REGS");
  end

  typedef logic [N_PORTS-1:0] np_mask_t;

  logic [N_REGS*N_PORTS-1:0] w_mask_flat;
  logic [N_REGS*N_PORTS-1:0] w_wdata_flat;
  logic [N_REGS-1:0]         w_we;

  np_mask_t              w_mask    [N_REGS];
  np_mask_t              w_arr     [N_REGS];
  np_mask_t              w_new     [N_REGS];
  logic [N_REGS-1:0]     w_complete;
  logic [ID_WIDTH-1:0]   w_id      [N_PORTS];
  np_mask_t              w_sel     [N_PORTS];
  logic [N_PORTS-1:0]    w_valid;

  for (genvar r = 0; r < N_REGS; r++) begin : g_unpack_mask
    assign w_mask[r] = w_mask_flat[r*N_PORTS +: N_PORTS];
  end
  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack_id
    assign w_id[i] = id_i[i*ID_WIDTH +: ID_WIDTH];
  end

  // Per-port lookup and error classification. The entry lookup yields 0 for
  // an out-of-range ID, so such a port can never look present or valid.
  always_comb begin
    id_err_o  = '0;
    dup_err_o = '0;
    present_o = '0;
    w_valid   = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      w_sel[i] = '0;
      for (int r = 0; r < int'(N_REGS); r++) begin
        if (int'(w_id[i]) == r) w_sel[i] = w_mask[r];
      end
      id_err_o[i]  = check_i[i] & ((int'(w_id[i]) >= int'(N_REGS)) | ~part_mask_i[i]);
      dup_err_o[i] = check_i[i] & ~id_err_o[i] & w_sel[i][i];
      present_o[i] = check_i[i] & ~id_err_o[i] & (w_sel[i] != '0);
      w_valid[i]   = check_i[i] & ~id_err_o[i] & ~w_sel[i][i];
    end
  end

  // Merge simultaneous arrivals per entry and detect completion.
  always_comb begin
    bypass_o = 1'b0;
    for (int r = 0; r < int'(N_REGS); r++) begin
      w_arr[r] = '0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
        if (w_valid[i] && (int'(w_id[i]) == r)) w_arr[r][i] = 1'b1;
      end
      w_new[r]      = w_mask[r] | w_arr[r];
      w_complete[r] = (w_arr[r] != '0) && ((w_new[r] & part_mask_i) == part_mask_i);
      if (w_complete[r] && (w_mask[r] == '0)) bypass_o = 1'b1;
    end
  end

  // done is only raised for valid ports, whose ID is known to be in range.
  always_comb begin
    done_o = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      for (int r = 0; r < int'(N_REGS); r++) begin
        if (w_valid[i] && (int'(w_id[i]) == r) && w_complete[r]) done_o[i] = 1'b1;
      end
    end
  end

  // Only entries that received arrivals are written; a completing entry is
  // freed instead of storing its full mask. clear_i overrides in storage.
  always_comb begin
    for (int r = 0; r < int'(N_REGS); r++) begin
      w_we[r] = (w_arr[r] != '0);
      w_wdata_flat[r*N_PORTS +: N_PORTS] = w_complete[r] ? '0 : w_new[r];
      pending_o[r] = (w_mask[r] != '0);
    end
  end

  fractal_sync_mask_rf #(
    .N_REGS  (N_REGS),
    .N_PORTS (N_PORTS)
  ) u_mask_rf (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clear (clear_i),
    .i_we    (w_we),
    .i_wdata (w_wdata_flat),
    .o_mask  (w_mask_flat)
  );

endmodule

// File: tb/tb_fractal_sync_np_local_rf.sv
module tb_fractal_sync_np_local_rf;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] id_i;
  logic [3:0] check_i;
  logic [3:0] part_mask_i;
  logic       clear_i;
  logic [3:0] present_o, done_o, id_err_o, dup_err_o;
  logic       bypass_o;
  logic [3:0] pending_o;

  logic [3:0] present3, done3, id_err3, dup_err3;
  logic       bypass3;
  logic [2:0] pending3;

  int checks = 0;
  int errors = 0;

  fractal_sync_np_local_rf #(.N_REGS(4), .ID_WIDTH(2), .N_PORTS(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .id_i        (id_i),
    .check_i     (check_i),
    .part_mask_i (part_mask_i),
    .clear_i     (clear_i),
    .present_o   (present_o),
    .done_o      (done_o),
    .id_err_o    (id_err_o),
    .dup_err_o   (dup_err_o),
    .bypass_o    (bypass_o),
    .pending_o   (pending_o)
  );

  // Three-entry instance for the out-of-range ID case.
  fractal_sync_np_local_rf #(.N_REGS(3), .ID_WIDTH(2), .N_PORTS(4)) dut3 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .id_i        (id_i),
    .check_i     (check_i),
    .part_mask_i (part_mask_i),
    .clear_i     (clear_i),
    .present_o   (present3),
    .done_o      (done3),
    .id_err_o    (id_err3),
    .dup_err_o   (dup_err3),
    .bypass_o    (bypass3),
    .pending_o   (pending3)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Driver tasks
  task automatic idle();
    check_i = '0;
    id_i    = '0;
    clear_i = 1'b0;
  endtask

  task automatic chk(input int p, input int id);
    check_i[p]      = 1'b1;
    id_i[p*2 +: 2]  = 2'(id);
  endtask

  // Start a new cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    part_mask_i = 4'b1111;
    idle();
    #12;
    check("reset_pending",  32'(pending_o), 32'h0);
    check("reset_done",     32'(done_o),    32'h0);
    check("reset_present",  32'(present_o), 32'h0);
    check("reset_bypass",   32'(bypass_o),  32'h0);
    check("reset_id_err3",  32'(id_err3),   32'h0);
    rst_ni = 1'b1;

    // Staggered arrivals on id 2
    next_cycle(); chk(0, 2); settle();
    check("stag0_present", 32'(present_o), 32'h0);
    check("stag0_pending", 32'(pending_o), 32'h0);
    check("stag0_done",    32'(done_o),    32'h0);
    next_cycle(); chk(1, 2); settle();
    check("stag1_present", 32'(present_o), 32'h2);
    check("stag1_pending", 32'(pending_o), 32'h4);
    check("stag1_done",    32'(done_o),    32'h0);
    next_cycle(); chk(2, 2); settle();
    check("stag2_present", 32'(present_o), 32'h4);
    check("stag2_done",    32'(done_o),    32'h0);
    next_cycle(); chk(3, 2); settle();
    check("stag3_present", 32'(present_o), 32'h8);
    check("stag3_done",    32'(done_o),    32'h8);
    check("stag3_bypass",  32'(bypass_o),  32'h0);
    check("stag3_pending", 32'(pending_o), 32'h4);
    next_cycle(); settle();
    check("stag4_pending", 32'(pending_o), 32'h0);

    // Simultaneous arrivals on id 1
    next_cycle(); chk(0, 1); chk(1, 1); chk(2, 1); chk(3, 1); settle();
    check("sim_done",    32'(done_o),    32'hf);
    check("sim_present", 32'(present_o), 32'h0);
    check("sim_bypass",  32'(bypass_o),  32'h1);
    next_cycle(); settle();
    check("sim_pending", 32'(pending_o), 32'h0);

    // Errors with two participants (ports 0 and 1)
    part_mask_i = 4'b0011;
    next_cycle(); chk(2, 0); settle();
    check("err_nonpart_id_err", 32'(id_err_o), 32'h4);
    check("err_nonpart_done",   32'(done_o),   32'h0);
    next_cycle(); settle();
    check("err_nonpart_pending", 32'(pending_o), 32'h0);
    // id 3 is out of range only in the three-entry instance
    next_cycle(); chk(0, 3); chk(1, 3); settle();
    check("err_range_id_err3", 32'(id_err3),  32'h3);
    check("err_range_done3",   32'(done3),    32'h0);
    check("err_range_done",    32'(done_o),   32'h3);
    check("err_range_bypass",  32'(bypass_o), 32'h1);
    next_cycle(); chk(0, 1); settle();
    check("dup_first_dup", 32'(dup_err_o), 32'h0);
    next_cycle(); chk(0, 1); settle();
    check("dup_second_dup",     32'(dup_err_o), 32'h1);
    check("dup_second_present", 32'(present_o), 32'h1);
    check("dup_second_done",    32'(done_o),    32'h0);
    next_cycle(); settle();
    check("dup_pending_kept", 32'(pending_o), 32'h2);
    next_cycle(); chk(1, 1); settle();
    check("dup_finish_done",   32'(done_o),   32'h2);
    check("dup_finish_bypass", 32'(bypass_o), 32'h0);
    next_cycle(); settle();
    check("dup_finish_pending", 32'(pending_o), 32'h0);
    part_mask_i = 4'b1111;

    // Mixed IDs across two cycles
    next_cycle(); chk(0, 0); chk(1, 0); chk(2, 3); chk(3, 3); settle();
    check("mix0_done", 32'(done_o), 32'h0);
    next_cycle(); chk(2, 0); chk(3, 0); chk(0, 3); chk(1, 3); settle();
    check("mix1_pending", 32'(pending_o), 32'h9);
    check("mix1_present", 32'(present_o), 32'hf);
    check("mix1_done",    32'(done_o),    32'hf);
    check("mix1_bypass",  32'(bypass_o),  32'h0);
    next_cycle(); settle();
    check("mix2_pending", 32'(pending_o), 32'h0);

    // Synchronous clear
    next_cycle(); chk(0, 2); chk(1, 2); settle();
    next_cycle(); clear_i = 1'b1; settle();
    check("clr_before", 32'(pending_o), 32'h4);
    next_cycle(); settle();
    check("clr_after", 32'(pending_o), 32'h0);

    // Asynchronous reset mid-cycle
    next_cycle(); chk(0, 2); chk(1, 2); settle();
    next_cycle(); #1;
    check("rst_before", 32'(pending_o), 32'h4);
    rst_ni = 1'b0;
    #1;
    check("rst_async_pending", 32'(pending_o), 32'h0);
    #10;
    rst_ni = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
